// File: rtl/csa_pkg.sv
// Shared constants and operand/result types for the carry-select adder and subtractor.
// The subtractor's optional borrow counter (CSA_SUB_BORROW_CNT_EN) takes its width from here.
`timescale 1ns/1ps
package csa_pkg;

    localparam int CSA_WIDTH     = 20;
    localparam int CSA_BLOCK     = 10;
    localparam int CSA_CNT_WIDTH = 16;

    typedef logic [CSA_WIDTH-1:0] operand_t;
    typedef logic [CSA_WIDTH:0]   result_t;

endpackage

// File: rtl/csa_sub_block.sv
// Combinational BLOCK-bit dual-borrow subtractor.
// Produces the difference and borrow-out for both possible borrow-in values.
`timescale 1ns/1ps
module csa_sub_block #(
    parameter int BLOCK = 10
) (
    input  logic [BLOCK-1:0] a_i,
    input  logic [BLOCK-1:0] b_i,
    output logic [BLOCK-1:0] diff0_o,
    output logic             borrow0_o,
    output logic [BLOCK-1:0] diff1_o,
    output logic             borrow1_o
);

    // The extra top bit of each widened subtraction is the borrow-out.
    assign {borrow0_o, diff0_o} = {1'b0, a_i} - {1'b0, b_i};
    assign {borrow1_o, diff1_o} = {1'b0, a_i} - {1'b0, b_i} - (BLOCK+1)'(1);

endmodule

// File: rtl/csa_sub_20b.sv
// Two-stage pipelined carry-select subtractor with valid/ready handshake.
// Define CSA_SUB_BORROW_CNT_EN to add the saturating borrow_cnt output.
`timescale 1ns/1ps
module csa_sub_20b
    import csa_pkg::*;
#(
    parameter int WIDTH = CSA_WIDTH,
    parameter int BLOCK = CSA_BLOCK
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_diff
`ifdef CSA_SUB_BORROW_CNT_EN
    ,
    output logic [CSA_CNT_WIDTH-1:0] borrow_cnt
`endif
);

    localparam int NUP = WIDTH / BLOCK - 1;

    logic s1Ready, s2Ready, accept;
    logic s1Valid_q, s2Valid_q;

    logic [BLOCK-1:0] lowDiff_d, lowDiff_q;
    logic             lowBorrow_d, lowBorrow_q;

    logic [NUP-1:0][BLOCK-1:0] upDiff0_d, upDiff0_q, upDiff1_d, upDiff1_q;
    logic [NUP-1:0]            upBorrow0_d, upBorrow0_q, upBorrow1_d, upBorrow1_q;

    logic [WIDTH:0] outDiff_d, outDiff_q;
    logic           selBorrow;

    assign s2Ready   = !s2Valid_q || out_ready;
    assign s1Ready   = !s1Valid_q || s2Ready;
    assign in_ready  = s1Ready && !reset;
    assign accept    = in_valid && in_ready;
    assign out_valid = s2Valid_q;
    assign out_diff  = outDiff_q;

    assign {lowBorrow_d, lowDiff_d} = {1'b0, a[BLOCK-1:0]} - {1'b0, b[BLOCK-1:0]};

    for (genvar i = 0; i < NUP; i++) begin : gUpper
        csa_sub_block #(
            .BLOCK(BLOCK)
        ) uBlock (
            .a_i      (a[(i+1)*BLOCK +: BLOCK]),
            .b_i      (b[(i+1)*BLOCK +: BLOCK]),
            .diff0_o  (upDiff0_d[i]),
            .borrow0_o(upBorrow0_d[i]),
            .diff1_o  (upDiff1_d[i]),
            .borrow1_o(upBorrow1_d[i])
        );
    end

    // Stage 2: the registered low borrow ripples through the precomputed upper blocks.
    always_comb begin
        selBorrow              = lowBorrow_q;
        outDiff_d              = '0;
        outDiff_d[BLOCK-1:0]   = lowDiff_q;
        for (int i = 0; i < NUP; i++) begin
            outDiff_d[(i+1)*BLOCK +: BLOCK] = selBorrow ? upDiff1_q[i] : upDiff0_q[i];
            selBorrow                       = selBorrow ? upBorrow1_q[i] : upBorrow0_q[i];
        end
        outDiff_d[WIDTH] = selBorrow;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1Valid_q <= 1'b0;
            s2Valid_q <= 1'b0;
            outDiff_q <= '0;
        end else begin
            if (s1Ready) begin
                s1Valid_q <= in_valid;
            end
            if (accept) begin
                lowDiff_q   <= lowDiff_d;
                lowBorrow_q <= lowBorrow_d;
                upDiff0_q   <= upDiff0_d;
                upDiff1_q   <= upDiff1_d;
                upBorrow0_q <= upBorrow0_d;
                upBorrow1_q <= upBorrow1_d;
            end
            if (s2Ready) begin
                s2Valid_q <= s1Valid_q;
                if (s1Valid_q) begin
                    outDiff_q <= outDiff_d;
                end
            end
        end
    end

`ifdef CSA_SUB_BORROW_CNT_EN
    logic [CSA_CNT_WIDTH-1:0] borrowCnt_q;

    // Counts delivered borrowing results, sticking at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            borrowCnt_q <= '0;
        end else if (out_valid && out_ready && out_diff[WIDTH] && (borrowCnt_q != '1)) begin
            borrowCnt_q <= borrowCnt_q + 1'b1;
        end
    end

    assign borrow_cnt = borrowCnt_q;
`endif

endmodule

// File: tb/tb_csa_sub_20b.sv
// Directed and streamed self-checking bench for csa_sub_20b.
// Borrow-counter checks are compiled in when CSA_SUB_BORROW_CNT_EN is defined.
`timescale 1ns/1ps
module tb_csa_sub_20b;
    import csa_pkg::*;

    logic     clk       = 1'b0;
    logic     reset     = 1'b1;
    logic     in_valid  = 1'b0;
    logic     out_ready = 1'b0;
    operand_t a         = '0;
    operand_t b         = '0;
    logic     in_ready;
    logic     out_valid;
    result_t  out_diff;
`ifdef CSA_SUB_BORROW_CNT_EN
    logic [CSA_CNT_WIDTH-1:0] borrowCnt;
`endif

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    csa_sub_20b dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_diff (out_diff)
`ifdef CSA_SUB_BORROW_CNT_EN
        ,
        .borrow_cnt(borrowCnt)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Presents one pair on an empty pipeline and checks the two-cycle latency and result.
    task automatic applyStimulus(input string tag, input operand_t x, input operand_t y, input result_t expDiff);
        a         = x;
        b         = y;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        checkOutput({tag, "_rdy"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput({tag, "_early"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        checkOutput({tag, "_vld"}, 32'(out_valid), 32'd1);
        checkOutput({tag, "_diff"}, 32'(out_diff), 32'(expDiff));
        @(posedge clk); #1;
    endtask

    initial begin
        result_t expQ[$];
        int      sent;
        int      got;
        int      stall;
        bit      stallPending;
        bit      sawDrop;
        bit      accepted;

        $display("[TB] start");
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("reset_vld", 32'(out_valid), 32'd0);
        checkOutput("reset_diff", 32'(out_diff), 32'd0);
        checkOutput("reset_rdy", 32'(in_ready), 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("post_reset_rdy", 32'(in_ready), 32'd1);

        applyStimulus("d5m3",   20'h00005, 20'h00003, 21'h000002);
        applyStimulus("d0m1",   20'h00000, 20'h00001, 21'h1FFFFF);
        applyStimulus("dFm0",   20'hFFFFF, 20'h00000, 21'h0FFFFF);
        applyStimulus("dx400",  20'h00400, 20'h00001, 21'h0003FF);
        applyStimulus("d0mF",   20'h00000, 20'hFFFFF, 21'h100001);

        // Stream of 100 random pairs with a three-cycle sink stall after the second accept.
        sent         = 0;
        got          = 0;
        stall        = 0;
        stallPending = 1'b0;
        sawDrop      = 1'b0;
        a            = 20'($urandom);
        b            = 20'($urandom);
        in_valid     = 1'b1;
        for (int cyc = 0; cyc < 2000 && got < 100; cyc++) begin
            out_ready = (stall == 0);
            accepted  = 1'b0;
            @(negedge clk);
            if (!in_ready) sawDrop = 1'b1;
            if (in_valid && in_ready) begin
                expQ.push_back(result_t'({1'b0, a} - {1'b0, b}));
                sent++;
                accepted = 1'b1;
                if (sent == 2) stallPending = 1'b1;
            end
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("stream_extra", 32'(out_diff), 32'hFFFFFFFF);
                end else begin
                    checkOutput("stream_diff", 32'(out_diff), 32'(expQ.pop_front()));
                end
                got++;
            end
            @(posedge clk); #1;
            if (stall > 0) stall--;
            if (stallPending) begin
                stall        = 3;
                stallPending = 1'b0;
            end
            if (accepted) begin
                if (sent < 100) begin
                    a = 20'($urandom);
                    b = 20'($urandom);
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        checkOutput("stream_backpressure", 32'(sawDrop), 32'd1);
        checkOutput("stream_count", 32'(got), 32'd100);
        checkOutput("stream_leftover", 32'(expQ.size()), 32'd0);

        // Fill both stages, then reset mid-stream.
        out_ready = 1'b0;
        a         = 20'h00009;
        b         = 20'h00002;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        a = 20'h00001;
        b = 20'h00008;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("full_rdy", 32'(in_ready), 32'd0);
        checkOutput("full_vld", 32'(out_valid), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        checkOutput("midrst_vld", 32'(out_valid), 32'd0);
        checkOutput("midrst_rdy", 32'(in_ready), 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("midrst_after_rdy", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checkOutput("no_stale", 32'(out_valid), 32'd0);
        end
        applyStimulus("after_rst", 20'h12345, 20'h02345, 21'h010000);

`ifdef CSA_SUB_BORROW_CNT_EN
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        checkOutput("cnt_reset", 32'(borrowCnt), 32'd0);
        applyStimulus("cnt_0m1", 20'h00000, 20'h00001, 21'h1FFFFF);
        applyStimulus("cnt_3m5", 20'h00003, 20'h00005, 21'h1FFFFE);
        applyStimulus("cnt_5m3", 20'h00005, 20'h00003, 21'h000002);
        checkOutput("cnt_two", 32'(borrowCnt), 32'd2);

        reset = 1'b1;
        @(posedge clk); #1;
        reset     = 1'b0;
        a         = 20'h00000;
        b         = 20'h00001;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        repeat (65545) @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("cnt_saturate", 32'(borrowCnt), 32'h0000FFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
